axi_lite_reg_master: RTL and testbench

AXI_LITE_REG_MASTER -- requirements
Module: axi_lite_reg_master

---
 rtl/axi_lite_reg_master.sv | 265 ++++++++++++++++++++++++++
 tb/tb_axi_lite_reg_master.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_reg_master.sv
// axi_lite_reg_master: turns single register read/write commands into
// AXI4-Lite transactions, one outstanding at a time, and returns the result
// on a valid/ready response port.
// Optional feature macro: AXIL_MASTER_TIMEOUT_EN enables a response timeout
// that aborts a stalled transaction with rsp_resp=2'b11 and rdata 0xDEADBEEF.
// Without the macro the master waits indefinitely and timeout_cnt reads 0.
module axi_lite_reg_master #(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDRESS     = 32'h00000000,
  parameter int                            C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  // command port
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  // response port
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  // AXI4-Lite master
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,
  // status
  output logic                            busy,
  output logic [15:0]                     timeout_cnt
);

  localparam logic [C_M_AXI_DATA_WIDTH-1:0] TIMEOUT_RDATA = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic                            aw_done_reg;
  logic                            w_done_reg;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_reg;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_reg;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_reg;
  logic                            rsp_write_reg;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_reg;
  logic [1:0]                      rsp_resp_reg;

  logic accept;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic ar_hs;
  logic r_hs;
  logic active;
  logic timeout_hit;
  logic take_timeout;

  assign accept = cmd_valid && cmd_ready;
  assign aw_hs  = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs   = M_AXI_WVALID && M_AXI_WREADY;
  assign b_hs   = M_AXI_BVALID && M_AXI_BREADY;
  assign ar_hs  = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_hs   = M_AXI_RVALID && M_AXI_RREADY;

  // The timer only runs while a bus transaction is in flight.
  assign active = (state_reg == WR_REQ) || (state_reg == WR_RESP) ||
                  (state_reg == RD_REQ) || (state_reg == RD_DATA);

`ifdef AXIL_MASTER_TIMEOUT_EN
  logic [15:0] timer_reg;
  logic [15:0] timeout_cnt_reg;

  // The timer reaches C_TIMEOUT_CYCLES on the edge where this fires.
  assign timeout_hit = active && (timer_reg == 16'(C_TIMEOUT_CYCLES - 1));
  assign timeout_cnt = timeout_cnt_reg;

  // Response timer and saturating count of aborted transactions.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      timer_reg       <= '0;
      timeout_cnt_reg <= '0;
    end else begin
      if (accept) begin
        timer_reg <= '0;
      end else if (active) begin
        timer_reg <= timer_reg + 16'd1;
      end
      if (take_timeout && (timeout_cnt_reg != 16'hFFFF)) begin
        timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
      end
    end
  end
`else
  logic [15:0] unused_timeout_cfg;

  assign unused_timeout_cfg = 16'(C_TIMEOUT_CYCLES);
  assign timeout_hit        = 1'b0;
  assign timeout_cnt        = '0;
`endif

  // State register.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a normal completion wins over a coincident timeout.
  always_comb begin
    state_next   = state_reg;
    take_timeout = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = cmd_write ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
          state_next = WR_RESP;
        end else if (timeout_hit) begin
          state_next   = RSP;
          take_timeout = 1'b1;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          state_next = RSP;
        end else if (timeout_hit) begin
          state_next   = RSP;
          take_timeout = 1'b1;
        end
      end
      RD_REQ: begin
        if (ar_hs) begin
          state_next = RD_DATA;
        end else if (timeout_hit) begin
          state_next   = RSP;
          take_timeout = 1'b1;
        end
      end
      RD_DATA: begin
        if (r_hs) begin
          state_next = RSP;
        end else if (timeout_hit) begin
          state_next   = RSP;
          take_timeout = 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Per-state handshake outputs; BREADY/RREADY stay high in IDLE to drain strays.
  always_comb begin
    cmd_ready     = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_RREADY  = 1'b0;
    rsp_valid     = 1'b0;
    busy          = 1'b1;
    case (state_reg)
      IDLE: begin
        cmd_ready    = M_AXI_ARESETN;
        M_AXI_BREADY = 1'b1;
        M_AXI_RREADY = 1'b1;
        busy         = 1'b0;
      end
      WR_REQ: begin
        M_AXI_AWVALID = !aw_done_reg;
        M_AXI_WVALID  = !w_done_reg;
      end
      WR_RESP: M_AXI_BREADY  = 1'b1;
      RD_REQ:  M_AXI_ARVALID = 1'b1;
      RD_DATA: M_AXI_RREADY  = 1'b1;
      RSP:     rsp_valid     = 1'b1;
      default: busy          = 1'b0;
    endcase
  end

  // Command capture, per-channel write progress and response payload.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      rsp_write_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_resp_reg  <= '0;
    end else begin
      if (accept) begin
        addr_reg    <= cmd_addr | C_BASE_ADDRESS;
        wdata_reg   <= cmd_wdata;
        wstrb_reg   <= cmd_wstrb;
        aw_done_reg <= 1'b0;
        w_done_reg  <= 1'b0;
      end
      if (state_reg == WR_REQ) begin
        if (aw_hs) aw_done_reg <= 1'b1;
        if (w_hs)  w_done_reg  <= 1'b1;
      end
      if ((state_reg == WR_RESP) && b_hs) begin
        rsp_resp_reg  <= M_AXI_BRESP;
        rsp_rdata_reg <= '0;
        rsp_write_reg <= 1'b1;
      end
      if ((state_reg == RD_DATA) && r_hs) begin
        rsp_resp_reg  <= M_AXI_RRESP;
        rsp_rdata_reg <= M_AXI_RDATA;
        rsp_write_reg <= 1'b0;
      end
      if (take_timeout) begin
        rsp_resp_reg  <= 2'b11;
        rsp_rdata_reg <= TIMEOUT_RDATA;
        rsp_write_reg <= (state_reg == WR_REQ) || (state_reg == WR_RESP);
      end
    end
  end

  assign M_AXI_AWADDR = addr_reg;
  assign M_AXI_ARADDR = addr_reg;
  assign M_AXI_WDATA  = wdata_reg;
  assign M_AXI_WSTRB  = wstrb_reg;
  assign rsp_write    = rsp_write_reg;
  assign rsp_rdata    = rsp_rdata_reg;
  assign rsp_resp     = rsp_resp_reg;

endmodule

// File: tb/tb_axi_lite_reg_master.sv
// Testbench for axi_lite_reg_master: directed commands against a small
// configurable AXI4-Lite slave; expected responses go into a scoreboard
// queue and a monitor compares each response handshake against it.
module tb_axi_lite_reg_master;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic        busy;
  logic [15:0] timeout_cnt;

  always #5 clk = ~clk;

  axi_lite_reg_master #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(32),
    .C_BASE_ADDRESS    (BASE),
    .C_TIMEOUT_CYCLES  (16)
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESETN(aresetn),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_write    (rsp_write),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .M_AXI_AWADDR (awaddr),
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA  (wdata),
    .M_AXI_WSTRB  (wstrb),
    .M_AXI_WVALID (wvalid),
    .M_AXI_WREADY (wready),
    .M_AXI_BRESP  (bresp),
    .M_AXI_BVALID (bvalid),
    .M_AXI_BREADY (bready),
    .M_AXI_ARADDR (araddr),
    .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA  (rdata),
    .M_AXI_RRESP  (rresp),
    .M_AXI_RVALID (rvalid),
    .M_AXI_RREADY (rready),
    .busy         (busy),
    .timeout_cnt  (timeout_cnt)
  );

  // ---------------- slave model ----------------
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;
  logic        inject_b = 1'b0;
  int          aw_wait, w_wait, ar_wait, r_cnt;
  logic        aw_got, w_got, r_pend;

  assign awready = awvalid && (aw_wait >= aw_delay);
  assign wready  = wvalid && (w_wait >= w_delay);
  assign arready = arvalid && (ar_wait >= ar_delay);

  always @(posedge clk) begin
    if (!aresetn) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
      bvalid <= 1'b0; bresp <= 2'b00;
      rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
    end else begin
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
      ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
      if (awvalid && awready) aw_got <= 1'b1;
      if (wvalid && wready) w_got <= 1'b1;
      if (bvalid && bready) bvalid <= 1'b0;
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
        bvalid <= 1'b1; bresp <= bresp_cfg; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (inject_b) begin
        bvalid <= 1'b1; bresp <= 2'b00;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        if (r_delay == 0) begin
          rvalid <= 1'b1; rdata <= rdata_cfg; rresp <= rresp_cfg;
        end else begin
          r_pend <= 1'b1; r_cnt <= r_delay - 1;
        end
      end else if (r_pend) begin
        if (r_cnt == 0) begin
          rvalid <= 1'b1; rdata <= rdata_cfg; rresp <= rresp_cfg; r_pend <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          lat;
    int          aw_n, w_n, ar_n, b_n;
    logic        chk_addr;
    logic [31:0] addr;
    logic        chk_w;
    logic [31:0] wd;
    logic [3:0]  ws;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic wr, input logic [31:0] rd, input logic [1:0] resp,
                      input int lat, input int aw_n, input int w_n, input int ar_n,
                      input int b_n, input logic ca, input logic [31:0] addr,
                      input logic cw, input logic [31:0] wd, input logic [3:0] ws);
    exp_t e;
    e.wr = wr; e.rdata = rd; e.resp = resp; e.lat = lat;
    e.aw_n = aw_n; e.w_n = w_n; e.ar_n = ar_n; e.b_n = b_n;
    e.chk_addr = ca; e.addr = addr; e.chk_w = cw; e.wd = wd; e.ws = ws;
    sb.push_back(e);
  endtask

  // ---------------- monitor ----------------
  int          acc_cyc = 0, first_cyc = 0;
  int          aw_n = 0, w_n = 0, ar_n = 0, b_n = 0;
  logic [31:0] aw_addr_seen = '0, ar_addr_seen = '0, wdata_seen = '0;
  logic [3:0]  wstrb_seen = '0;
  logic        prev_valid = 1'b0, prev_hold = 1'b0;
  logic        prev_write = 1'b0;
  logic [31:0] prev_rdata = '0;
  logic [1:0]  prev_resp = '0;

  always @(negedge clk) begin
    if (!aresetn) begin
      prev_valid = 1'b0;
      prev_hold  = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        acc_cyc = cyc; aw_n = 0; w_n = 0; ar_n = 0; b_n = 0;
      end
      if (awvalid) aw_n++;
      if (wvalid) w_n++;
      if (arvalid) ar_n++;
      if (bvalid && bready) b_n++;
      if (awvalid && awready) aw_addr_seen = awaddr;
      if (arvalid && arready) ar_addr_seen = araddr;
      if (wvalid && wready) begin
        wdata_seen = wdata; wstrb_seen = wstrb;
      end
      if (rsp_valid && !prev_valid) first_cyc = cyc;
      if (prev_hold) begin
        chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("hold_rsp_rdata", rsp_rdata, prev_rdata);
        chk("hold_rsp_resp", 32'(rsp_resp), 32'(prev_resp));
        chk("hold_rsp_write", 32'(rsp_write), 32'(prev_write));
      end
      if (rsp_valid && !rsp_ready) chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rdata %h resp %0d with empty scoreboard", rsp_rdata, rsp_resp);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("rsp: write=%0d rdata=%h resp=%0d latency=%0d", rsp_write, rsp_rdata, rsp_resp, first_cyc - acc_cyc);
          chk("rsp_write", 32'(rsp_write), 32'(e.wr));
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
          if (e.lat >= 0)  chk("latency", 32'(first_cyc - acc_cyc), 32'(e.lat));
          if (e.aw_n >= 0) chk("awvalid_cycles", 32'(aw_n), 32'(e.aw_n));
          if (e.w_n >= 0)  chk("wvalid_cycles", 32'(w_n), 32'(e.w_n));
          if (e.ar_n >= 0) chk("arvalid_cycles", 32'(ar_n), 32'(e.ar_n));
          if (e.b_n >= 0)  chk("b_handshakes", 32'(b_n), 32'(e.b_n));
          if (e.chk_addr)  chk("axi_addr", e.wr ? aw_addr_seen : ar_addr_seen, e.addr);
          if (e.chk_w) begin
            chk("axi_wdata", wdata_seen, e.wd);
            chk("axi_wstrb", 32'(wstrb_seen), 32'(e.ws));
          end
        end
      end
      prev_hold  = rsp_valid && !rsp_ready;
      prev_valid = rsp_valid;
      prev_write = rsp_write;
      prev_rdata = rsp_rdata;
      prev_resp  = rsp_resp;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] ws);
    int guard;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!cmd_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_accept: cmd_ready stayed 0 for %0d cycles", guard);
    end else begin
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || busy || rsp_valid) && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (sb.size() != 0 || busy || rsp_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL txn_timeout: %0d responses still pending after %0d cycles", sb.size(), guard);
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_awvalid", 32'(awvalid), 32'd0);
    chk("reset_wvalid", 32'(wvalid), 32'd0);
    chk("reset_arvalid", 32'(arvalid), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_timeout_cnt", 32'(timeout_cnt), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_resp", 32'(rsp_resp), 32'd0);
    chk("reset_awaddr", awaddr, 32'd0);
    aresetn = 1'b1;
    @(posedge clk); #1;
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("idle_bready", 32'(bready), 32'd1);
    chk("idle_rready", 32'(rready), 32'd1);

    // zero-wait write
    push(1'b1, 32'h0, 2'b00, 3, 1, 1, 0, 1, 1'b1, 32'h4000_0010, 1'b1, 32'hA5A5_A5A5, 4'hF);
    issue(1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF);
    wait_done();

    // read, ARREADY after 2 waits, RVALID 5 cycles late
    ar_delay = 2; r_delay = 5; rdata_cfg = 32'hDEAD_BEEF; rresp_cfg = 2'b00;
    push(1'b0, 32'hDEAD_BEEF, 2'b00, 10, 0, 0, 3, 0, 1'b1, 32'h4000_000C, 1'b0, 32'h0, 4'h0);
    issue(1'b0, 32'h0C, 32'h0, 4'h0);
    wait_done();
    ar_delay = 0; r_delay = 0;

    // skewed write channels, SLVERR response
    w_delay = 3; bresp_cfg = 2'b10;
    push(1'b1, 32'h0, 2'b10, 6, 1, 4, 0, 1, 1'b1, 32'h4000_0020, 1'b1, 32'h1234_5678, 4'h3);
    issue(1'b1, 32'h20, 32'h1234_5678, 4'h3);
    wait_done();
    w_delay = 0; bresp_cfg = 2'b00;

    // back-pressure on the response port
    rdata_cfg = 32'h0BAD_F00D; rresp_cfg = 2'b10; rsp_ready = 1'b0;
    push(1'b0, 32'h0BAD_F00D, 2'b10, 3, 0, 0, 1, 0, 1'b1, 32'h4000_0004, 1'b0, 32'h0, 4'h0);
    issue(1'b0, 32'h04, 32'h0, 4'h0);
    guard = 0;
    while (!rsp_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (10) begin
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    wait_done();
    rresp_cfg = 2'b00;

    // another zero-wait write with partial strobes
    push(1'b1, 32'h0, 2'b00, 3, 1, 1, 0, 1, 1'b1, 32'h4000_003C, 1'b1, 32'hFFFF_0000, 4'hC);
    issue(1'b1, 32'h3C, 32'hFFFF_0000, 4'hC);
    wait_done();

    // reset in RD_DATA abandons the read
    r_delay = 1000;
    issue(1'b0, 32'h08, 32'h0, 4'h0);
    guard = 0;
    while (!(busy && !arvalid) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("rd_data_reached", 32'(busy && !arvalid && rready), 32'd1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    aresetn = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_arvalid", 32'(arvalid), 32'd0);
    chk("midrst_awvalid", 32'(awvalid), 32'd0);
    chk("midrst_wvalid", 32'(wvalid), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    aresetn = 1'b1;
    r_delay = 0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("postrst_cmd_ready", 32'(cmd_ready), 32'd1);

`ifdef AXIL_MASTER_TIMEOUT_EN
    // slave never accepts AW: write times out
    aw_delay = 1000;
    push(1'b1, 32'hDEAD_BEEF, 2'b11, -1, -1, 1, 0, 0, 1'b0, 32'h0, 1'b1, 32'h1111_1111, 4'hF);
    issue(1'b1, 32'h50, 32'h1111_1111, 4'hF);
    wait_done();
    aw_delay = 0;
    chk("timeout_cnt", 32'(timeout_cnt), 32'd1);
    // late BVALID while idle is drained without touching rsp_*
    inject_b = 1'b1;
    @(posedge clk); #1;
    inject_b = 1'b0;
    chk("stray_bvalid_seen", 32'(bvalid), 32'd1);
    chk("stray_bready", 32'(bready), 32'd1);
    @(posedge clk); #1;
    chk("stray_drained", 32'(bvalid), 32'd0);
    chk("stray_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("stray_rsp_resp", 32'(rsp_resp), 32'd3);
    chk("stray_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
`else
    chk("timeout_cnt_disabled", 32'(timeout_cnt), 32'd0);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
